// File: rtl/mem_writer.sv
// Burst writer: moves a valid/ready byte stream, or a constant fill, into a
// memory write port at one registered write per cycle.
module mem_writer #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  fill_mode,
    input  logic [DATA_WIDTH-1:0] fill_value,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned LEN_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FILL   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_W-1:0]      remaining_q;
    logic [DATA_WIDTH-1:0] fill_value_q;
    logic                  issue;
    logic                  last_word;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign last_word = (remaining_q == LEN_W'(1));

    // Next-state logic; start in IDLE takes priority over abort
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        state_d = S_DONE;
                    end else if (fill_mode) begin
                        state_d = S_FILL;
                    end else begin
                        state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (in_valid && last_word) begin
                    state_d = S_DONE;
                end
            end
            S_FILL: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (last_word) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State decodes; a beat accepted on the abort cycle still issues its write
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        issue    = 1'b0;
        case (state_q)
            S_STREAM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                issue    = in_valid;
            end
            S_FILL: begin
                busy  = 1'b1;
                issue = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Burst operands, address/count tracking and the registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            remaining_q  <= '0;
            fill_value_q <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
        end else begin
            mem_we <= issue;
            if (state_q == S_IDLE && start) begin
                addr_q       <= base_addr;
                remaining_q  <= length;
                fill_value_q <= fill_value;
            end else if (issue) begin
                addr_q      <= addr_q + ADDR_WIDTH'(1);
                remaining_q <= remaining_q - LEN_W'(1);
            end
            if (issue) begin
                mem_addr <= addr_q;
                mem_data <= (state_q == S_FILL) ? fill_value_q : in_data;
            end
        end
    end

endmodule
